// File: rtl/fso_payload_arbiter.sv
// fso_payload_arbiter: frame-granular round-robin share of the framer payload
// port between s0 (user) and s1 (mgmt). Optional fill frames: FSO_ARB_FILL_EN.
module fso_payload_arbiter #(
    parameter int              W                = 32,
    parameter int              PAYLOAD_WORDS    = 16,
    parameter int              FRAMES_PER_BLOCK = 255,
    parameter logic [W-1:0]    FILL_WORD        = 32'hA5A5_5A5A
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s0_data,
    input  logic         s0_valid,
    input  logic         s0_frame_rdy,
    output logic         s0_ready,
    input  logic [W-1:0] s1_data,
    input  logic         s1_valid,
    input  logic         s1_frame_rdy,
    output logic         s1_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    output logic         m_block_start,
    input  logic         m_ready,
    output logic [1:0]   o_grant,
    output logic [15:0]  o_frame_in_block,
    output logic [15:0]  o_fill_count
);

    localparam int WCW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam int FCW = (FRAMES_PER_BLOCK > 1) ? $clog2(FRAMES_PER_BLOCK) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(PAYLOAD_WORDS - 1);
    localparam logic [FCW-1:0] FLAST = FCW'(FRAMES_PER_BLOCK - 1);

    typedef enum logic [1:0] {SEL, GNT0, GNT1, FILL} state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           ptr_q, ptr_d;
    logic [1:0]     grant_q, grant_d;
    logic           xfer;
`ifdef FSO_ARB_FILL_EN
    logic [15:0]    fill_cnt_q, fill_cnt_d;
`endif

    // Grant decision, owner mux and word/frame bookkeeping.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        frame_cnt_d = frame_cnt_q;
        ptr_d       = ptr_q;
`ifdef FSO_ARB_FILL_EN
        fill_cnt_d  = fill_cnt_q;
`endif
        m_data      = '0;
        m_valid     = 1'b0;
        s0_ready    = 1'b0;
        s1_ready    = 1'b0;
        unique case (state_q)
            SEL: begin
                if (s0_frame_rdy && s1_frame_rdy) begin
                    state_d = ptr_q ? GNT1 : GNT0;
                    ptr_d   = ~ptr_q;
                end else if (s0_frame_rdy) begin
                    state_d = GNT0;
                    ptr_d   = 1'b1;
                end else if (s1_frame_rdy) begin
                    state_d = GNT1;
                    ptr_d   = 1'b0;
                end
`ifdef FSO_ARB_FILL_EN
                else if (frame_cnt_q != '0) begin
                    state_d = FILL;
                end
`endif
            end
            GNT0: begin
                m_data   = s0_data;
                m_valid  = s0_valid;
                s0_ready = m_ready;
            end
            GNT1: begin
                m_data   = s1_data;
                m_valid  = s1_valid;
                s1_ready = m_ready;
            end
`ifdef FSO_ARB_FILL_EN
            FILL: begin
                m_data  = FILL_WORD;
                m_valid = 1'b1;
            end
`endif
            default: ;
        endcase

        xfer = m_valid & m_ready;
        if (xfer) begin
            if (word_cnt_q == WLAST) begin
                word_cnt_d  = '0;
                state_d     = SEL;
                frame_cnt_d = (frame_cnt_q == FLAST) ? '0 : frame_cnt_q + 1'b1;
`ifdef FSO_ARB_FILL_EN
                if (state_q == FILL && fill_cnt_q != 16'hFFFF) begin
                    fill_cnt_d = fill_cnt_q + 16'd1;
                end
`endif
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end

        grant_d = {state_d == GNT1, state_d == GNT0};
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEL;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
            ptr_q       <= 1'b0;
            grant_q     <= 2'b00;
`ifdef FSO_ARB_FILL_EN
            fill_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
`ifdef FSO_ARB_FILL_EN
            fill_cnt_q  <= fill_cnt_d;
`endif
        end
    end

    assign m_block_start    = (word_cnt_q == '0) && (frame_cnt_q == '0) && m_valid;
    assign o_grant          = grant_q;
    assign o_frame_in_block = 16'(frame_cnt_q);
`ifdef FSO_ARB_FILL_EN
    assign o_fill_count     = fill_cnt_q;
`else
    assign o_fill_count     = 16'd0;
`endif

endmodule
